spi_master: RTL and testbench

Initiator end of the on-chip SPI link: accepts a parallel byte and a slave index from the host, asserts the selected active-low chip select, shifts the byte out MSB-first on MOSI while simultaneously shifting the slave's response in from MISO, then returns the received byte with a one-cycle done pulse. SCLK is the shared bus clock, generated externally and fed to both this block and every slave; this block never gates or drives it. It is paired with the existing SPI slave, which presents its MSB on MISO at CS fall and samples MOSI and shifts MISO on posedge SCLK.

---
 rtl/spi_master.sv | 101 ++++++++++
 tb/tb_spi_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI initiator that shifts one word MSB-first per transfer on the externally supplied SCLK,
// capturing the selected slave's MISO response in parallel.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  slaveSelect,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    input  logic                  MISO,
    output logic                  MOSI,
    output logic [NUM_SLAVES-1:0] CS,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  selError
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int GW = $clog2(CS_GAP) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rcv;
    logic [NUM_SLAVES-1:0] r_cs;
    logic [CW-1:0]         r_cnt;
    logic [GW-1:0]         r_gap;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sel_err;
    logic                  w_sel_ok;
    assign w_sel_ok           = 32'(slaveSelect) < NUM_SLAVES;
    assign MOSI               = r_mosi;
    assign CS                 = r_cs;
    assign masterDataReceived = r_rcv;
    assign busy               = r_busy;
    assign done               = r_done;
    assign selError           = r_sel_err;
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rcv     <= '0;
            r_cs      <= '1;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_sel_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_sel_ok) begin
                        r_tx    <= masterDataToSend;
                        r_cs    <= ~(NUM_SLAVES'(1) << slaveSelect);
                        r_mosi  <= masterDataToSend[DATA_WIDTH-1];
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else if (start) begin
                        r_sel_err <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_rx   <= {r_rx[DATA_WIDTH-2:0], MISO};
                    r_tx   <= r_tx << 1;
                    r_mosi <= r_tx[DATA_WIDTH-2];
                    r_cnt  <= r_cnt + 1'b1;
                    // last bit: the completion edge itself counts as the first CS-high gap cycle
                    if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                        r_rcv   <= {r_rx[DATA_WIDTH-2:0], MISO};
                        r_cs    <= '1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_busy  <= CS_GAP > 1;
                        r_state <= CS_GAP > 1 ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (r_gap == GW'(CS_GAP - 2)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized bench for spi_master with a behavioural SPI slave on every chip select.
module tb_spi_master;
    localparam int DW  = 8;
    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int GAP = 2;

    logic          reset = 1'b1;
    logic          SCLK = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] slaveSelect = '0;
    logic [DW-1:0] masterDataToSend = '0;
    logic          MISO;
    logic          MOSI;
    logic [NS-1:0] CS;
    logic [DW-1:0] masterDataReceived;
    logic          busy;
    logic          done;
    logic          selError;
    logic [DW-1:0] resp [NS];
    logic [DW-1:0] s_rx;
    int            s_cnt;
    int            checks = 0;
    int            errors = 0;

    spi_master #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_WIDTH(SW), .CS_GAP(GAP)) dut (
        .reset(reset), .SCLK(SCLK), .start(start), .slaveSelect(slaveSelect),
        .masterDataToSend(masterDataToSend), .MISO(MISO), .MOSI(MOSI), .CS(CS),
        .masterDataReceived(masterDataReceived), .busy(busy), .done(done), .selError(selError)
    );

    always #5 SCLK = ~SCLK;

    // Slave: MSB on MISO at CS fall, samples MOSI and advances MISO on each posedge while selected
    always @(posedge SCLK or posedge reset) begin
        if (reset) s_cnt <= 0;
        else if (CS != '1) begin
            s_cnt <= s_cnt + 1;
            s_rx  <= {s_rx[DW-2:0], MOSI};
        end else s_cnt <= 0;
    end

    always_comb begin
        MISO = 1'bz;
        for (int i = 0; i < NS; i++)
            if (!CS[i] && s_cnt < DW) MISO = resp[i][DW-1-s_cnt];
    end

    task automatic run_xfer(input logic [SW-1:0] sel, input logic [DW-1:0] data,
                            output int lat, output int cs_ok,
                            output logic [DW-1:0] got_m, output logic [DW-1:0] got_s);
        cs_ok = 0;
        @(negedge SCLK);
        start = 1'b1; slaveSelect = sel; masterDataToSend = data;
        @(negedge SCLK);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (CS == ~(NS'(1) << sel)) cs_ok++;
            @(negedge SCLK);
            lat++;
        end
        got_m = masterDataReceived;
        got_s = s_rx;
        for (int i = 0; i < 10 && busy; i++) @(negedge SCLK);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge SCLK);
        checks++;
        if (CS !== '1 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || selError !== 1'b0 || masterDataReceived !== '0) begin
            errors++;
            $display("FAIL reset: CS=%b MOSI=%b busy=%b done=%b selError=%b rx=%h, required CS=111 others 0", CS, MOSI, busy, done, selError, masterDataReceived);
        end
        reset = 1'b0;
        repeat (3) @(negedge SCLK);
        checks++;
        if (CS !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: CS=%b busy=%b done=%b, required 111/0/0", CS, busy, done);
        end
    endtask

    task automatic test_loopback;
        int lat, cs_ok;
        logic [DW-1:0] m, s;
        resp[0] = 8'h3C;
        run_xfer(2'd0, 8'hA5, lat, cs_ok, m, s);
        checks++; if (lat !== DW) begin errors++; $display("FAIL loopback_latency: got %0d required %0d", lat, DW); end
        checks++; if (cs_ok !== DW) begin errors++; $display("FAIL loopback_cs_low: got %0d required %0d", cs_ok, DW); end
        checks++; if (m !== 8'h3C) begin errors++; $display("FAIL loopback_master_rx: got %h required 3c", m); end
        checks++; if (s !== 8'hA5) begin errors++; $display("FAIL loopback_slave_rx: got %h required a5", s); end
        checks++;
        if (MOSI !== 1'b0 || CS !== '1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loopback_end: MOSI=%b CS=%b busy=%b required 0/111/0", MOSI, CS, busy);
        end
    endtask

    task automatic test_random;
        int lat, cs_ok;
        logic [DW-1:0] m, s, data, r;
        logic [SW-1:0] sel;
        for (int n = 0; n < 12; n++) begin
            sel = SW'($urandom_range(0, NS - 1));
            data = DW'($urandom);
            r = DW'($urandom);
            resp[sel] = r;
            run_xfer(sel, data, lat, cs_ok, m, s);
            checks++; if (lat !== DW) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", n, lat, DW); end
            checks++; if (cs_ok !== DW) begin errors++; $display("FAIL rand_cs_low[%0d]: sel %0d got %0d required %0d", n, sel, cs_ok, DW); end
            checks++; if (m !== r) begin errors++; $display("FAIL rand_master_rx[%0d]: got %h required %h", n, m, r); end
            checks++; if (s !== data) begin errors++; $display("FAIL rand_slave_rx[%0d]: got %h required %h", n, s, data); end
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        logic exp_low, exp_done;
        logic [DW-1:0] m1, s1, m2, s2, r1, r2;
        bad = 0;
        r1 = DW'($urandom); r2 = DW'($urandom);
        @(negedge SCLK);
        start = 1'b1; slaveSelect = 2'd2; masterDataToSend = 8'h01; resp[2] = r1;
        for (int i = 0; i < 24; i++) begin
            @(negedge SCLK);
            exp_low  = (i % (DW + GAP)) < DW && i < 2 * (DW + GAP);
            exp_done = (i % (DW + GAP)) == DW && i < 2 * (DW + GAP);
            if (CS[2] !== !exp_low || CS[1:0] !== 2'b11 || done !== exp_done) bad++;
            if (i == 0) masterDataToSend = 8'hFF;
            if (i == DW) begin m1 = masterDataReceived; s1 = s_rx; resp[2] = r2; end
            if (i == 2 * DW + GAP) begin m2 = masterDataReceived; s2 = s_rx; start = 1'b0; end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_cs_timing: %0d bad cycles required 0", bad); end
        checks++; if (m1 !== r1 || s1 !== 8'h01) begin errors++; $display("FAIL b2b_first: master %h slave %h required %h/01", m1, s1, r1); end
        checks++; if (m2 !== r2 || s2 !== 8'hFF) begin errors++; $display("FAIL b2b_second: master %h slave %h required %h/ff", m2, s2, r2); end
    endtask

    task automatic test_ignored_start;
        int lows, dones;
        logic [DW-1:0] m, s, r;
        logic [SW-1:0] sel;
        lows = 0; dones = 0;
        sel = SW'($urandom_range(0, NS - 1));
        r = DW'($urandom);
        @(negedge SCLK);
        start = 1'b1; slaveSelect = sel; masterDataToSend = 8'hA5; resp[sel] = r;
        for (int i = 0; i < 24; i++) begin
            @(negedge SCLK);
            start = (i == 2);
            if (i == 2) masterDataToSend = 8'h55;
            if (CS != '1) lows++;
            if (done) begin dones++; m = masterDataReceived; s = s_rx; end
        end
        checks++; if (lows !== DW) begin errors++; $display("FAIL ignored_cs_low: got %0d required %0d", lows, DW); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d required 1", dones); end
        checks++; if (m !== r || s !== 8'hA5) begin errors++; $display("FAIL ignored_data: master %h slave %h required %h/a5", m, s, r); end
    endtask

    task automatic test_bad_select;
        @(negedge SCLK);
        start = 1'b1; slaveSelect = 2'd3; masterDataToSend = DW'($urandom);
        @(negedge SCLK);
        start = 1'b0;
        checks++;
        if (selError !== 1'b1 || CS !== '1 || busy !== 1'b0 || done !== 1'b0 || MOSI !== 1'b0) begin
            errors++;
            $display("FAIL bad_sel_pulse: selError=%b CS=%b busy=%b done=%b MOSI=%b required 1/111/0/0/0", selError, CS, busy, done, MOSI);
        end
        @(negedge SCLK);
        checks++;
        if (selError !== 1'b0 || CS !== '1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_sel_after: selError=%b CS=%b busy=%b required 0/111/0", selError, CS, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat, cs_ok;
        logic [DW-1:0] m, s, r;
        resp[0] = DW'($urandom);
        @(negedge SCLK);
        start = 1'b1; slaveSelect = 2'd0; masterDataToSend = DW'($urandom);
        @(negedge SCLK);
        start = 1'b0;
        repeat (4) @(negedge SCLK);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (CS !== '1 || masterDataReceived !== '0 || busy !== 1'b0 || MOSI !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: CS=%b rx=%h busy=%b MOSI=%b done=%b required 111/00/0/0/0", CS, masterDataReceived, busy, MOSI, done);
        end
        @(negedge SCLK);
        reset = 1'b0;
        r = DW'($urandom);
        resp[1] = r;
        run_xfer(2'd1, 8'hC3, lat, cs_ok, m, s);
        checks++; if (lat !== DW || cs_ok !== DW) begin errors++; $display("FAIL post_reset_timing: lat %0d cs_low %0d required %0d", lat, cs_ok, DW); end
        checks++; if (m !== r || s !== 8'hC3) begin errors++; $display("FAIL post_reset_data: master %h slave %h required %h/c3", m, s, r); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) resp[i] = '0;
        test_reset;
        test_loopback;
        test_random;
        test_back_to_back;
        test_ignored_start;
        test_bad_select;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
